// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } uart_sched_state_t;

    localparam int DATA_W_DEF = 8;

    // Counter width able to hold max_val; a zero-length count still gets one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // Scan from lowest to highest priority so the candidate nearest ptr is written last.
    always_comb begin : arb_search
        int cand;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr_i) + k) % N;
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end else begin
                gnt_o = gnt_o;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter: accept a byte, start the frame,
// wait for completion (or time out), then hold an idle gap before the next grant.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_start_o,
    output logic [DATA_W-1:0]          tx_data_o,
    input  logic                       tx_done_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       err_timeout_o
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    uart_sched_state_t  state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               err_q, err_d;
    logic               start_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDW-1:0]     arb_idx_s;
    logic               idle_s;
    logic               accept_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s)
    );

    // Ready is also masked by the reset pin so it drops the instant reset asserts.
    assign idle_s      = rst_ni & (state_q == S_IDLE);
    assign accept_s    = idle_s & (|arb_gnt_s);
    assign req_ready_o = idle_s ? arb_gnt_s : '0;

    // Next-state, data latch and counter updates.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        grant_d   = grant_q;
        gap_cnt_d = gap_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    data_d  = req_data_i[arb_idx_s*DATA_W +: DATA_W];
                    grant_d = arb_idx_s;
                    ptr_d   = (arb_idx_s == IDW'(NUM_REQ - 1)) ? '0 : arb_idx_s + IDW'(1);
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                // A completion in the same cycle as the timeout takes precedence.
                if (tx_done_i) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            data_q    <= '0;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
            start_q   <= accept_s;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign tx_start_o    = start_q;
    assign tx_data_o     = data_q;
    assign grant_id_o    = grant_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and directed checking of uart_tx_scheduler against a timeline model.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 16;
    localparam int TMO = 50;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_done = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_timeout;

    uart_tx_scheduler #(
        .NUM_REQ        (N),
        .DATA_W         (DW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .tx_done_i     (tx_done),
        .grant_id_o    (grant_id),
        .busy_o        (busy),
        .err_timeout_o (err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a frame is a timeline of absolute cycle numbers fixed at accept time.
    int cyc = 0;
    int ptr_m, id_m;
    logic [DW-1:0] data_m;
    int acc_c, done_c, tmo_c, send_end, idle_from;

    logic          v [N];
    logic [DW-1:0] d [N];
    int            vmode, done_mode, fixed_delay, stray_mode;
    logic [N-1:0]  fmask;
    logic [DW-1:0] fdata [N];

    int gid_q[$], gdata_q[$], rdy_q[$], start_q[$], err_q[$], done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic reset_model();
        ptr_m = 0; id_m = 0; data_m = '0;
        acc_c = -100; done_c = -1; tmo_c = -100; send_end = -100; idle_from = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
    endtask

    task automatic clear_logs();
        gid_q.delete(); gdata_q.delete(); rdy_q.delete();
        start_q.delete(); err_q.delete(); done_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        tx_done = 1'b0;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] one;
        logic         done_s, in_send, idle;
        int           win, delay, r;
        one = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (vmode == 1) begin
                v[i] = fmask[i];
                d[i] = fdata[i];
            end else if (!v[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    v[i] = 1'b1;
                    d[i] = DW'($urandom);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                v[i] = 1'b0;
            end
            req_valid[i]          = v[i];
            req_data[i*DW +: DW]  = d[i];
        end
        in_send = (cyc >= acc_c + 2) && (cyc <= send_end);
        if (in_send) done_s = (cyc == done_c);
        else if (stray_mode == 2) done_s = 1'b1;
        else done_s = (stray_mode == 1) && ($urandom_range(0, 7) == 0);
        tx_done = done_s;

        idle = (cyc >= idle_from);
        win = -1;
        if (idle) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && v[(ptr_m + k) % N]) win = (ptr_m + k) % N;
            end
        end
        exp_rdy = (win >= 0) ? (one << win) : '0;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        chk("tx_start", tx_start, cyc == acc_c + 1);
        chk("busy", busy, !idle);
        chk("tx_data", tx_data, data_m);
        chk("grant_id", grant_id, id_m);
        chk("err_timeout", err_timeout, cyc == tmo_c + 1);

        if (tx_start) begin
            start_q.push_back(cyc);
            gid_q.push_back(grant_id);
            gdata_q.push_back(tx_data);
        end
        if (err_timeout) err_q.push_back(cyc);
        if (req_ready != '0) rdy_q.push_back(cyc);
        if (in_send && done_s) done_q.push_back(cyc);

        if (win >= 0) begin
            data_m = d[win];
            id_m   = win;
            ptr_m  = (win + 1) % N;
            acc_c  = cyc;
            if (done_mode == 1) delay = fixed_delay;
            else if (done_mode == 2) delay = TMO;
            else begin
                r = $urandom_range(0, 9);
                delay = (r < 2) ? TMO : (r == 2) ? TMO - 1 : $urandom_range(0, TMO - 1);
            end
            if (delay >= TMO) begin
                done_c   = -1;
                tmo_c    = acc_c + TMO + 1;
                send_end = tmo_c;
            end else begin
                done_c   = acc_c + 2 + delay;
                tmo_c    = -100;
                send_end = done_c;
            end
            idle_from = send_end + GAP + 1;
            if (vmode == 0) v[win] = 1'b0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_model();
        vmode = 1; fmask = '0; done_mode = 1; fixed_delay = 20; stray_mode = 0;
        for (int i = 0; i < N; i++) fdata[i] = '0;
        do_reset();

        // Single request with stray tx_done in every non-SEND cycle.
        clear_logs();
        stray_mode = 2;
        fmask = 4'b0010; fdata[1] = 8'hA5;
        step();
        fmask = '0;
        run(50);
        chk("single_gid", gid_q[0], 1);
        chk("single_data", gdata_q[0], 32'hA5);
        chk("single_latency", start_q[0] - rdy_q[0], 1);

        // Round-robin with every requester continuously valid.
        do_reset();
        clear_logs();
        stray_mode = 0; fixed_delay = 30; fmask = 4'b1111;
        for (int i = 0; i < N; i++) fdata[i] = DW'(8'h10 + i);
        run(260);
        chk("rr_count", gid_q.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            chk("rr_gid", gid_q[i], i % N);
            chk("rr_data", gdata_q[i], 32'h10 + (i % N));
        end
        chk("gap_next_ready", rdy_q[1] - done_q[0], GAP + 1);

        // Timeout when the transmitter never completes.
        do_reset();
        clear_logs();
        done_mode = 2; fmask = 4'b0001;
        step();
        fmask = '0;
        run(90);
        chk("tmo_count", err_q.size(), 1);
        chk("tmo_delay", err_q[0] - (start_q[0] + 1), TMO);

        // Randomized traffic.
        do_reset();
        vmode = 0; done_mode = 0; stray_mode = 1;
        run(3000);

        // Asynchronous reset in the middle of SEND.
        do_reset();
        vmode = 1; done_mode = 2; stray_mode = 0; fmask = 4'b0100; fdata[2] = 8'h5C;
        step();
        fmask = '0;
        run(5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        check_all_zero("midsend_rst");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        clear_logs();
        done_mode = 1; fixed_delay = 10; fmask = 4'b1000; fdata[3] = 8'h3E;
        step();
        fmask = '0;
        run(40);
        chk("post_rst_gid", gid_q[0], 3);
        chk("post_rst_data", gdata_q[0], 32'h3E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
